// File: rtl/mmc1_serial_writer.sv
// mmc1_serial_writer
//
// Bus-master transmitter for the MMC1 serial register port. One parallel
// register write (2-bit register select, 5-bit value) becomes the CPU-bus
// write sequence the mapper expects:
//   - an optional $80 shift-register reset write to $8000;
//   - then five D0 writes, LSB first, to the selected register address.
// Every write is followed by idle bus cycles so the mapper's fast-write
// filter never drops a write.
//
// Parameters:
//   PRE_RESET   1: send a $80 reset write before every value; 0: data only.
//   GAP_CYCLES  ce-qualified idle cycles after each write (values < 1 act as 1).
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high; clears all state
//   ce              M2 bus-cycle enable; the bus samples outputs on ce edges
//   req_valid       request present
//   req_ready       high only while idle; accept = req_valid & req_ready
//   req_reg         target register (0 control, 1 CHR0, 2 CHR1, 3 PRG)
//   req_data        5-bit value to load
//   req_reset_only  send only the $80 reset write
//   bus_addr        write address ($8000/$A000/$C000/$E000)
//   bus_dout        write data ($80 for reset, {7'b0, bit} for data)
//   bus_write       write strobe
//   busy            high from acceptance until done
//   done            one-clk pulse when the sequence and its last gap finish
module mmc1_serial_writer #(
  parameter bit PRE_RESET  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_reg,
  input  logic [4:0]  req_data,
  input  logic        req_reset_only,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_write,
  output logic        busy,
  output logic        done
);

  // A gap of zero would allow two back-to-back write cycles, which the
  // mapper filters out, so the effective gap is clamped to at least one.
  localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GW      = $clog2(GAP_EFF + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_EFF);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    reg_q, reg_d;
  logic [4:0]    data_q, data_d;
  logic          ro_q, ro_d;
  logic [15:0]   addr_d;
  logic [7:0]    dout_d;
  logic          write_d, busy_d, done_d, ready_d;
  logic [2:0]    last_slot;

  // Slot 0 is the shift-register reset write; slots 1..5 carry data bits
  // 0..4 and all go to the register's address (bit 15 set, bits 14:13 = reg).
  function automatic logic [15:0] slot_addr(input logic [2:0] k, input logic [1:0] r);
    logic [15:0] a;
    a = {1'b1, r, 13'h0000};
    if (k == 3'd0) a = 16'h8000;
    return a;
  endfunction

  function automatic logic [7:0] slot_dout(input logic [2:0] k, input logic [4:0] d);
    logic bit_v;
    bit_v = 1'b0;
    case (k)
      3'd1:    bit_v = d[0];
      3'd2:    bit_v = d[1];
      3'd3:    bit_v = d[2];
      3'd4:    bit_v = d[3];
      3'd5:    bit_v = d[4];
      default: bit_v = 1'b0;
    endcase
    return (k == 3'd0) ? 8'h80 : {7'b0000000, bit_v};
  endfunction

  // A reset-only transfer ends after its single slot 0; otherwise the
  // fifth data write is the last one.
  assign last_slot = ro_q ? 3'd0 : 3'd5;

  // State and registered outputs. Every output is a flop so the cart bus
  // sees clean, glitch-free values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= 3'd0;
      gap_q     <= '0;
      reg_q     <= 2'd0;
      data_q    <= 5'd0;
      ro_q      <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_dout  <= 8'h00;
      bus_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      gap_q     <= gap_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      ro_q      <= ro_d;
      bus_addr  <= addr_d;
      bus_dout  <= dout_d;
      bus_write <= write_d;
      busy      <= busy_d;
      done      <= done_d;
      req_ready <= ready_d;
    end
  end

  // Next-state logic. Address and data are only reloaded when entering
  // WRITE, so they stay stable throughout each gap. Without ce nothing
  // advances in WRITE or GAP.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    gap_d   = gap_q;
    reg_d   = reg_q;
    data_d  = data_q;
    ro_d    = ro_q;
    addr_d  = bus_addr;
    dout_d  = bus_dout;
    write_d = bus_write;
    busy_d  = busy;
    done_d  = 1'b0;
    ready_d = req_ready;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          reg_d   = req_reg;
          data_d  = req_data;
          ro_d    = req_reset_only;
          k_d     = (PRE_RESET || req_reset_only) ? 3'd0 : 3'd1;
          addr_d  = slot_addr(k_d, req_reg);
          dout_d  = slot_dout(k_d, req_data);
          write_d = 1'b1;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = WRITE;
        end
      end

      WRITE: begin
        if (ce) begin
          write_d = 1'b0;
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
      end

      GAP: begin
        if (ce) begin
          if (gap_q <= GW'(1)) begin
            gap_d = '0;
            if (k_q == last_slot) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              ready_d = 1'b1;
              state_d = IDLE;
            end else begin
              k_d     = k_q + 3'd1;
              addr_d  = slot_addr(k_d, reg_q);
              dout_d  = slot_dout(k_d, data_q);
              write_d = 1'b1;
              state_d = WRITE;
            end
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Self-checking bench for mmc1_serial_writer.
// Three instances cover the parameter space:
//   inst0: defaults (PRE_RESET=1, GAP_CYCLES=1)
//   inst1: PRE_RESET=0, GAP_CYCLES=1
//   inst2: PRE_RESET=0, GAP_CYCLES=3
// Stimulus pushes the expected bus writes into a queue; a monitor samples
// every ce-qualified write, pops and compares, and feeds a small MMC1
// shift-register model whose registers are checked against hand values.
module tb_mmc1_serial_writer;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  logic [2:0]       req_valid;
  logic [2:0]       req_reset_only;
  logic [2:0][1:0]  req_reg;
  logic [2:0][4:0]  req_data;
  logic [2:0]       req_ready;
  logic [2:0]       bus_write;
  logic [2:0]       busy;
  logic [2:0]       done;
  logic [2:0][15:0] bus_addr;
  logic [2:0][7:0]  bus_dout;

  int checks = 0;
  int fails  = 0;
  bit sparse = 1'b0;
  int ce_phase = 0;

  typedef struct {
    int          inst;
    logic [15:0] addr;
    logic [7:0]  dout;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int          gap_req [3] = '{1, 1, 3};
  bit          prev_w [3];
  int          idle_cnt [3];
  bit          have_last [3];
  logic [15:0] last_addr [3];
  logic [7:0]  last_dout [3];

  logic [4:0]  m_shift [3];
  int          m_cnt [3];
  logic [4:0]  m_regs [3][4];

  always #5 clk = ~clk;

  // ce changes 2 time units after each rising edge, so a read at #1 after
  // an edge still shows the ce value that edge used.
  always @(posedge clk) begin
    #2;
    if (sparse) begin
      ce_phase = (ce_phase + 1) % 3;
      ce = (ce_phase == 0);
    end else begin
      ce = 1'b1;
    end
  end

  mmc1_serial_writer #(.PRE_RESET(1'b1), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_reg(req_reg[0]), .req_data(req_data[0]),
    .req_reset_only(req_reset_only[0]),
    .bus_addr(bus_addr[0]), .bus_dout(bus_dout[0]),
    .bus_write(bus_write[0]), .busy(busy[0]), .done(done[0])
  );

  mmc1_serial_writer #(.PRE_RESET(1'b0), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_reg(req_reg[1]), .req_data(req_data[1]),
    .req_reset_only(req_reset_only[1]),
    .bus_addr(bus_addr[1]), .bus_dout(bus_dout[1]),
    .bus_write(bus_write[1]), .busy(busy[1]), .done(done[1])
  );

  mmc1_serial_writer #(.PRE_RESET(1'b0), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_reg(req_reg[2]), .req_data(req_data[2]),
    .req_reset_only(req_reset_only[2]),
    .bus_addr(bus_addr[2]), .bus_dout(bus_dout[2]),
    .bus_write(bus_write[2]), .busy(busy[2]), .done(done[2])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void push_expected(input int inst, input logic [1:0] r,
                                        input logic [4:0] d, input logic ro,
                                        input bit pre);
    wr_t w;
    if (ro || pre) begin
      w.inst = inst; w.addr = 16'h8000; w.dout = 8'h80;
      exp_q.push_back(w);
    end
    if (!ro) begin
      for (int b = 0; b < 5; b++) begin
        w.inst = inst;
        w.addr = {1'b1, r, 13'h0000};
        w.dout = {7'b0000000, d[b]};
        exp_q.push_back(w);
      end
    end
  endfunction

  // Bus monitor: at the falling edge ce already holds the value for the
  // next rising edge, so bus_write & ce here means the mapper takes a write.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        prev_w[i]    = 1'b0;
        idle_cnt[i]  = 99;
        have_last[i] = 1'b0;
      end
    end else if (ce) begin
      for (int i = 0; i < 3; i++) begin
        if (bus_write[i]) begin
          checkOutput($sformatf("inst%0d consecutive write", i), prev_w[i], 0);
          checkOutput($sformatf("inst%0d gap length ok", i), idle_cnt[i] >= gap_req[i], 1);
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL inst%0d unexpected write: got addr 0x%0h dout 0x%0h, expected none",
                     i, bus_addr[i], bus_dout[i]);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput($sformatf("inst%0d write instance", i), i, mon_e.inst);
            checkOutput($sformatf("inst%0d write addr", i), bus_addr[i], mon_e.addr);
            checkOutput($sformatf("inst%0d write dout", i), bus_dout[i], mon_e.dout);
          end
          if (bus_dout[i][7]) begin
            m_shift[i] = 5'd0;
            m_cnt[i]   = 0;
            m_regs[i][0] = m_regs[i][0] | 5'h0C;
          end else begin
            m_shift[i] = {bus_dout[i][0], m_shift[i][4:1]};
            m_cnt[i]++;
            if (m_cnt[i] == 5) begin
              m_regs[i][bus_addr[i][14:13]] = m_shift[i];
              m_shift[i] = 5'd0;
              m_cnt[i]   = 0;
            end
          end
          prev_w[i]    = 1'b1;
          idle_cnt[i]  = 0;
          have_last[i] = 1'b1;
          last_addr[i] = bus_addr[i];
          last_dout[i] = bus_dout[i];
        end else begin
          if (busy[i] && have_last[i]) begin
            checkOutput($sformatf("inst%0d gap addr hold", i), bus_addr[i], last_addr[i]);
            checkOutput($sformatf("inst%0d gap dout hold", i), bus_dout[i], last_dout[i]);
          end
          prev_w[i] = 1'b0;
          idle_cnt[i]++;
        end
      end
    end
  end

  // Issues one request and follows it to done. Starts and ends #1 after a
  // rising edge. With hold set, req_valid stays high for the next request.
  task automatic applyStimulus(input int inst, input logic [1:0] r, input logic [4:0] d,
                               input logic ro, input int exp_edges, input bit hold,
                               input string name);
    int n;
    int edges;
    push_expected(inst, r, d, ro, inst == 0);
    req_reg[inst]        = r;
    req_data[inst]       = d;
    req_reset_only[inst] = ro;
    req_valid[inst]      = 1'b1;
    n = 0;
    while (!req_ready[inst] && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checkOutput({name, " ready before accept"}, req_ready[inst], 1);
    @(posedge clk); #1;
    if (!hold) req_valid[inst] = 1'b0;
    checkOutput({name, " busy after accept"}, busy[inst], 1);
    checkOutput({name, " bus_write after accept"}, bus_write[inst], 1);
    checkOutput({name, " ready low while busy"}, req_ready[inst], 0);
    edges = 0;
    n = 0;
    while (!done[inst] && n < 500) begin
      @(posedge clk); #1; n++;
      if (ce) edges++;
    end
    checkOutput({name, " done seen"}, done[inst], 1);
    checkOutput({name, " latency ce edges"}, edges, exp_edges);
    checkOutput({name, " busy at done"}, busy[inst], 0);
    checkOutput({name, " ready at done"}, req_ready[inst], 1);
    if (!hold) begin
      @(posedge clk); #1;
      checkOutput({name, " done one pulse"}, done[inst], 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    req_valid      = '0;
    req_reset_only = '0;
    req_reg        = '0;
    req_data       = '0;
    for (int i = 0; i < 3; i++) begin
      m_shift[i] = 5'd0;
      m_cnt[i]   = 0;
      for (int j = 0; j < 4; j++) m_regs[i][j] = 5'd0;
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("inst%0d reset req_ready", i), req_ready[i], 1);
      checkOutput($sformatf("inst%0d reset busy", i), busy[i], 0);
      checkOutput($sformatf("inst%0d reset done", i), done[i], 0);
      checkOutput($sformatf("inst%0d reset bus_write", i), bus_write[i], 0);
      checkOutput($sformatf("inst%0d reset bus_addr", i), bus_addr[i], 16'h0000);
      checkOutput($sformatf("inst%0d reset bus_dout", i), bus_dout[i], 8'h00);
    end

    // Defaults: $80 then $00,$00,$01,$01,$00 at $8000, 12 clks.
    applyStimulus(0, 2'd0, 5'h0C, 1'b0, 12, 1'b0, "ctrl 0C");
    checkOutput("ctrl 0C mapper control", m_regs[0][0], 5'h0C);

    // Sparse ce: latency counted in ce edges.
    sparse = 1'b1;
    applyStimulus(0, 2'd1, 5'h15, 1'b0, 12, 1'b0, "sparse chr0 15");
    checkOutput("sparse mapper chr0", m_regs[0][1], 5'h15);
    sparse = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Control to $03, then a reset-only write ORs in $0C.
    applyStimulus(0, 2'd0, 5'h03, 1'b0, 12, 1'b0, "ctrl 03");
    checkOutput("ctrl 03 mapper control", m_regs[0][0], 5'h03);
    applyStimulus(0, 2'd3, 5'h1B, 1'b1, 2, 1'b0, "reset only");
    checkOutput("reset only mapper control", m_regs[0][0], 5'h0F);
    checkOutput("reset only prg untouched", m_regs[0][3], 5'h00);

    // Async reset during the third data write (slot 3) of a CHR1 = $0A load.
    push_expected(0, 2'd2, 5'h0A, 1'b0, 1'b1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    req_reg[0] = 2'd2;
    req_data[0] = 5'h0A;
    req_reset_only[0] = 1'b0;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    checkOutput("mid write bus_write", bus_write[0], 1);
    checkOutput("mid write addr", bus_addr[0], 16'hC000);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset bus_write", bus_write[0], 0);
    checkOutput("async reset busy", busy[0], 0);
    checkOutput("async reset req_ready", req_ready[0], 1);
    checkOutput("async reset bus_addr", bus_addr[0], 16'h0000);
    checkOutput("async reset bus_dout", bus_dout[0], 8'h00);
    checkOutput("async reset done", done[0], 0);
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("writes before reset consumed", exp_q.size(), 0);
    applyStimulus(0, 2'd2, 5'h0A, 1'b0, 12, 1'b0, "recover chr1 0A");
    checkOutput("recover mapper chr1", m_regs[0][2], 5'h0A);

    // No reset write: five writes at $E000 of $01, 10 clks.
    applyStimulus(1, 2'd3, 5'h1F, 1'b0, 10, 1'b0, "nopre prg 1F");
    checkOutput("nopre mapper prg", m_regs[1][3], 5'h1F);
    applyStimulus(1, 2'd2, 5'h11, 1'b1, 2, 1'b0, "nopre reset only");
    checkOutput("nopre reset only control", m_regs[1][0], 5'h0C);

    // Three-cycle gap: 5 * (1 + 3) = 20 ce edges.
    applyStimulus(2, 2'd1, 5'h0B, 1'b0, 20, 1'b0, "gap3 chr0 0B");
    checkOutput("gap3 mapper chr0", m_regs[2][1], 5'h0B);

    // Back-to-back with req_valid held across all four registers.
    applyStimulus(0, 2'd0, 5'h0E, 1'b0, 12, 1'b1, "b2b ctrl");
    applyStimulus(0, 2'd1, 5'h11, 1'b0, 12, 1'b1, "b2b chr0");
    applyStimulus(0, 2'd2, 5'h07, 1'b0, 12, 1'b1, "b2b chr1");
    applyStimulus(0, 2'd3, 5'h19, 1'b0, 12, 1'b0, "b2b prg");
    checkOutput("b2b mapper control", m_regs[0][0], 5'h0E);
    checkOutput("b2b mapper chr0", m_regs[0][1], 5'h11);
    checkOutput("b2b mapper chr1", m_regs[0][2], 5'h07);
    checkOutput("b2b mapper prg", m_regs[0][3], 5'h19);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("no leftover expected writes", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
